mux_word_serializer: RTL and testbench
======================================

# mux_word_serializer

Upstream sequencer for the 8-to-1 multiplexer stage. It accepts an 8-bit word through a valid/ready handshake and drives the word onto the mux data inputs. It then steps the 3-bit select through all eight positions and samples the mux output each time. The sampled bits leave as a serial stream with valid/ready backpressure and a last-bit marker.

## Interface
- MSB_FIRST, default 0: 0 → select order 0,1,…,7; 1 → select order 7,6,…,0.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word; high exactly in IDLE.
- mux_i  output  8  registered word driven to the mux data inputs.
- mux_s  output  3  registered select driven to the mux.
- mux_f  input  1  mux output, combinational function of mux_i/mux_s.
- ser_out  output  1  registered sampled bit.
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  downstream accepts ser_out.
- ser_last  output  1  ser_out is the 8th bit of the word; qualified by ser_valid.
- busy  output  1  high in SEL or SEND.

## Operation
- States:
  - IDLE: in_ready=1, ser_valid=0.
  - SEL: select is driven; the mux settles this cycle.
  - SEND: ser_valid=1; the block waits for ser_ready.
- Transitions:
  - IDLE → SEL on in_valid & in_ready.
    - Latch mux_i ← in_data.
    - mux_s ← 0 (MSB_FIRST=0) or 7 (MSB_FIRST=1).
    - Bit counter ← 0.
  - SEL → SEND unconditionally.
    - ser_out ← mux_f.
    - ser_last ← (counter == 7).
  - SEND, ser_ready=0: hold all outputs; ser_out must not change.
  - SEND, ser_ready=1, counter < 7:
    - counter +1.
    - mux_s +1 (LSB-first) or −1 (MSB-first), 3-bit.
    - Go to SEL.
  - SEND, ser_ready=1, counter == 7 → IDLE.
    - mux_s and mux_i hold their last values.
    - ser_valid drops.
- mux_s never wraps within a word. It starts at 0 or 7 and ends at 7 or 0 respectively.
- The bit counter is 3 bits wide; the counter == 7 comparison is the only termination condition.
- in_valid outside IDLE is ignored. The word is not captured and in_ready stays 0.
- Words are not accepted back-to-back. After the last handshake, at least one IDLE cycle occurs before the next accept.
- mux_f is sampled only in SEL. Its value in other states is don't-care.

## Timing
- Reset values: state=IDLE, in_ready=1, mux_i=8'h00, mux_s=3'b000, ser_out=0, ser_valid=0, ser_last=0, busy=0.
- Reset asserted mid-word: at the next edge all registers return to reset values, and the partial word is discarded with no further ser_valid. Reset has priority over every handshake in the same cycle.
- Accept at edge k: mux_i and mux_s are valid after edge k. ser_valid first rises after edge k+1.
- Each bit takes 2 cycles minimum (SEL + SEND) with ser_ready held high.
- Full word:
  - 16 cycles from the accept edge to the return to IDLE.
  - in_ready rises after the 16th edge.
  - The next accept is possible at the 17th edge.
- ser_valid, once high, stays high with stable ser_out/ser_last until the ser_ready handshake (no retraction).
- ser_ready=1 in SEL is ignored.

## Test plan
- Reset then idle, 4 cycles: in_ready=1, ser_valid=0, mux_s=0, mux_i=8'h00 on every cycle.
- LSB-first, in_data=8'hA5, ser_ready tied high:
  - mux_s=0..7.
  - Accepted bits 1,0,1,0,0,1,0,1.
  - ser_last only on the 8th bit.
  - in_ready high again 16 cycles after the accept.
- MSB_FIRST=1, in_data=8'h42, ser_ready high:
  - mux_s=7..0.
  - Bits 0,1,0,0,0,0,1,0.
- Backpressure, 8'hFF:
  - Hold ser_ready low for 5 cycles during bit 3.
  - ser_valid=1, ser_out=1 and mux_s=3 stay stable throughout.
  - The stream resumes with no lost or duplicated bit.
- Second word 8'h0F with in_valid held during the transfer of 8'h3C:
  - 8'h0F is ignored while busy.
  - It is accepted one cycle after the last 8'h3C handshake.
  - Both streams are correct.
- Reset mid-word, 8'hC3 after 3 accepted bits:
  - rst for 1 cycle; all outputs return to reset values next edge.
  - No further ser_valid appears.
  - A new 8'h81 serializes correctly afterwards.

Source files
------------

// File: rtl/mux_word_serializer_if.sv
// Handshake and mux-side bundle of the word serializer: word input, mux drive/sample, serial output.
interface mux_word_serializer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] mux_i;
  logic [2:0] mux_s;
  logic       mux_f;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_last;

  modport master (
    output in_data, in_valid, ser_ready, mux_f,
    input  in_ready, mux_i, mux_s, ser_out, ser_valid, ser_last
  );

  modport slave (
    input  in_data, in_valid, ser_ready, mux_f,
    output in_ready, mux_i, mux_s, ser_out, ser_valid, ser_last
  );
endinterface

// File: rtl/mux_word_serializer.sv
// Latches a word onto the 8:1 mux inputs, steps the select through all positions and
// streams each sampled mux output bit out with valid/ready backpressure and a last marker.
module mux_word_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  mux_word_serializer_if.slave         bus,
  output logic                         busy,
  output logic [1:0]                   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never drops and its payload never changes before that transfer completes.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] bit_cnt;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      bus.in_ready  <= 1'b1;
      bus.mux_i     <= 8'h00;
      bus.mux_s     <= 3'd0;
      bus.ser_out   <= 1'b0;
      bus.ser_valid <= 1'b0;
      bus.ser_last  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.mux_i    <= bus.in_data;
            bus.mux_s    <= MSB_FIRST ? 3'd7 : 3'd0;
            bit_cnt      <= 3'd0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= SEL;
          end
        end
        // The mux output has had a full cycle to settle on the select driven last edge.
        SEL: begin
          bus.ser_out   <= bus.mux_f;
          bus.ser_last  <= (bit_cnt == 3'd7);
          bus.ser_valid <= 1'b1;
          state         <= SEND;
        end
        SEND: begin
          if (bus.ser_ready) begin
            bus.ser_valid <= 1'b0;
            if (bit_cnt == 3'd7) begin
              bus.ser_last <= 1'b0;
              bus.in_ready <= 1'b1;
              busy         <= 1'b0;
              state        <= IDLE;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              bus.mux_s <= MSB_FIRST ? (bus.mux_s - 3'd1) : (bus.mux_s + 3'd1);
              state     <= SEL;
            end
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_word_serializer.sv
// Drives an LSB-first and an MSB-first serializer in lockstep and checks each stream
// against a per-word bit list built from the input word.
module tb_mux_word_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       ser_ready = 1'b0;
  logic       busy0, busy1;
  logic [1:0] dbg0, dbg1;

  int n_cmp = 0;
  int n_err = 0;

  mux_word_serializer_if if0 ();
  mux_word_serializer_if if1 ();

  assign if0.in_data   = in_data;
  assign if0.in_valid  = in_valid;
  assign if0.ser_ready = ser_ready;
  assign if0.mux_f     = if0.mux_i[if0.mux_s];
  assign if1.in_data   = in_data;
  assign if1.in_valid  = in_valid;
  assign if1.ser_ready = ser_ready;
  assign if1.mux_f     = if1.mux_i[if1.mux_s];

  mux_word_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(if0), .busy(busy0), .dbg_state(dbg0)
  );
  mux_word_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bus(if1), .busy(busy1), .dbg_state(dbg1)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // Scoreboard entries: {select, last, bit}
  logic [4:0] exp0_q[$];
  logic [4:0] exp1_q[$];

  task automatic check_idle_outputs(input string tag);
    n_cmp++;
    if ({if0.in_ready, if0.ser_valid, if0.mux_s, if0.mux_i, busy0} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL %s_lsb got rdy/val/sel/mux_i/busy=%b/%b/%0d/%h/%b required 1/0/0/00/0",
               tag, if0.in_ready, if0.ser_valid, if0.mux_s, if0.mux_i, busy0);
    end
    n_cmp++;
    if ({if1.in_ready, if1.ser_valid, if1.mux_s, if1.mux_i, busy1} !== {1'b1, 1'b0, 3'd0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL %s_msb got rdy/val/sel/mux_i/busy=%b/%b/%0d/%h/%b required 1/0/0/00/0",
               tag, if1.in_ready, if1.ser_valid, if1.mux_s, if1.mux_i, busy1);
    end
  endtask

  // Driver: offers word w, then consumes bits until stop_after bits of each stream are taken.
  task automatic send_word(input logic [7:0] w, input int stall_bit, input int stall_len,
                           input bit rnd, input bit hold_next, input logic [7:0] next_w,
                           input int stop_after);
    int guard = 0;
    int cyc = 0;
    int got0 = 0, got1 = 0;
    int stall_left = 0;
    int first_valid = -1;
    bit stalled = 0, done = 0, pend0 = 0, pend1 = 0, ready;
    while (!(if0.in_ready && if1.in_ready) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (guard >= 50) begin
      n_err++;
      $display("FAIL wait_in_ready got in_ready=%b/%b required 1/1", if0.in_ready, if1.in_ready);
    end
    exp0_q.delete();
    exp1_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp0_q.push_back({3'(i), (i == 7), w[i]});
      exp1_q.push_back({3'(7 - i), (i == 7), w[7 - i]});
    end
    in_data   = w;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    @(negedge clk);
    if (hold_next) in_data = next_w;
    else in_valid = 1'b0;
    n_cmp++;
    if ({if0.mux_i, if0.mux_s, if1.mux_i, if1.mux_s} !== {w, 3'd0, w, 3'd7}) begin
      n_err++;
      $display("FAIL accept_latch got mux_i/sel=%h/%0d,%h/%0d required %h/0,%h/7",
               if0.mux_i, if0.mux_s, if1.mux_i, if1.mux_s, w, w);
    end
    while (!done && cyc < 200) begin
      n_cmp++;
      if ({if0.in_ready, busy0, if0.mux_i, if1.in_ready, busy1, if1.mux_i} !== {1'b0, 1'b1, w, 1'b0, 1'b1, w}) begin
        n_err++;
        $display("FAIL busy_state cyc%0d got rdy/busy/mux_i=%b/%b/%h,%b/%b/%h required 0/1/%h", cyc,
                 if0.in_ready, busy0, if0.mux_i, if1.in_ready, busy1, if1.mux_i, w);
      end
      if (if0.ser_valid && first_valid < 0) first_valid = cyc;
      if (pend0) begin
        n_cmp++;
        if (!if0.ser_valid) begin n_err++; $display("FAIL retract_lsb cyc%0d got valid=0 required 1", cyc); end
      end
      if (pend1) begin
        n_cmp++;
        if (!if1.ser_valid) begin n_err++; $display("FAIL retract_msb cyc%0d got valid=0 required 1", cyc); end
      end
      if (stall_left == 0 && !stalled && stall_len > 0 && if0.ser_valid && got0 == stall_bit) begin
        stall_left = stall_len;
        stalled = 1;
      end
      if (stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else if (rnd) ready = 1'($urandom_range(0, 1));
      else ready = 1'b1;
      if (if0.ser_valid) begin
        n_cmp++;
        if (exp0_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_bit_lsb got valid=1 required no more bits");
        end else if ({if0.mux_s, if0.ser_last, if0.ser_out} !== exp0_q[0]) begin
          n_err++;
          $display("FAIL bit_lsb%0d got sel/last/bit=%0d/%b/%b required %0d/%b/%b", got0, if0.mux_s,
                   if0.ser_last, if0.ser_out, exp0_q[0][4:2], exp0_q[0][1], exp0_q[0][0]);
        end
      end
      if (if1.ser_valid) begin
        n_cmp++;
        if (exp1_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_bit_msb got valid=1 required no more bits");
        end else if ({if1.mux_s, if1.ser_last, if1.ser_out} !== exp1_q[0]) begin
          n_err++;
          $display("FAIL bit_msb%0d got sel/last/bit=%0d/%b/%b required %0d/%b/%b", got1, if1.mux_s,
                   if1.ser_last, if1.ser_out, exp1_q[0][4:2], exp1_q[0][1], exp1_q[0][0]);
        end
      end
      if (if0.ser_valid && ready && exp0_q.size() > 0) begin void'(exp0_q.pop_front()); got0++; end
      if (if1.ser_valid && ready && exp1_q.size() > 0) begin void'(exp1_q.pop_front()); got1++; end
      pend0 = if0.ser_valid && !ready;
      pend1 = if1.ser_valid && !ready;
      done = (got0 >= stop_after) && (got1 >= stop_after);
      ser_ready = ready;
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL stream_timeout got bits=%0d/%0d required %0d", got0, got1, stop_after);
    end
    if (done && stop_after == 8) begin
      n_cmp++;
      if ({if0.in_ready, if0.ser_valid, busy0, if0.mux_s, if1.in_ready, if1.ser_valid, busy1, if1.mux_s}
          !== {1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b0, 3'd0}) begin
        n_err++;
        $display("FAIL word_end got rdy/val/busy/sel=%b/%b/%b/%0d,%b/%b/%b/%0d required 1/0/0/7,1/0/0/0",
                 if0.in_ready, if0.ser_valid, busy0, if0.mux_s, if1.in_ready, if1.ser_valid, busy1, if1.mux_s);
      end
      if (!rnd && stall_len == 0) begin
        n_cmp++;
        if (cyc != 16 || first_valid != 1) begin
          n_err++;
          $display("FAIL word_timing got cycles=%0d first_valid=%0d required 16 and 1", cyc, first_valid);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle_outputs("reset_idle");
    end
  endtask

  task automatic test_basic_words();
    send_word(8'hA5, -1, 0, 0, 0, 8'h00, 8);
    send_word(8'h42, -1, 0, 0, 0, 8'h00, 8);
  endtask

  task automatic test_backpressure();
    send_word(8'hFF, 3, 5, 0, 0, 8'h00, 8);
  endtask

  task automatic test_back_to_back();
    send_word(8'h3C, -1, 0, 0, 1, 8'h0F, 8);
    send_word(8'h0F, -1, 0, 0, 0, 8'h00, 8);
  endtask

  task automatic test_reset_mid_word();
    send_word(8'hC3, -1, 0, 0, 0, 8'h00, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({if0.ser_out, if0.ser_last, if1.ser_out, if1.ser_last} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid_ser got out/last=%b%b,%b%b required 00,00",
               if0.ser_out, if0.ser_last, if1.ser_out, if1.ser_last);
    end
    check_idle_outputs("reset_mid");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({if0.ser_valid, if1.ser_valid, if0.in_ready, if1.in_ready} !== 4'b0011) begin
        n_err++;
        $display("FAIL reset_quiet got val/val/rdy/rdy=%b%b%b%b required 0011",
                 if0.ser_valid, if1.ser_valid, if0.in_ready, if1.in_ready);
      end
    end
    send_word(8'h81, -1, 0, 0, 0, 8'h00, 8);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      send_word(8'($urandom_range(0, 255)), -1, 0, 1, 0, 8'h00, 8);
    end
  endtask

  initial begin
    test_reset();
    test_basic_words();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
